// File: rtl/iconn_pkg.sv
// Shared definitions for the interconnect issue engine: FSM encoding and drain timeout offset.
package iconn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } iconn_state_e;

  // Drain timeout is NODE_ADDR_WIDTH plus this many cycles.
  localparam int unsigned DRAIN_OFFSET = 4;

endpackage

// File: rtl/iconn_popcount.sv
// Combinational population count of an N-bit vector.
module iconn_popcount #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 6
) (
  input  logic [N-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_o = cnt_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/iconn_issue.sv
// Issues per-round source reads into the interconnect and checks that every injected
// packet arrives before signalling completion.
module iconn_issue
  import iconn_pkg::*;
#(
  parameter int unsigned NODE_ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ROUND_WIDTH     = 8,
  localparam int unsigned NN             = 2 ** NODE_ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ROUND_WIDTH-1:0]              round_num,
  input  logic                                pause,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic                                src_rd_en,
  output logic [ROUND_WIDTH-1:0]              src_rd_round,
  input  logic [NN-1:0][NODE_ADDR_WIDTH-1:0]  src_rd_addr,
  input  logic [NN-1:0][DATA_WIDTH-1:0]       src_rd_data,
  input  logic [NN-1:0]                       src_rd_mask,
  output logic [NN-1:0][NODE_ADDR_WIDTH-1:0]  ain,
  output logic [NN-1:0][DATA_WIDTH-1:0]       din,
  output logic [NN-1:0]                       din_valid,
  input  logic [NN-1:0]                       dout_valid
);

  localparam int unsigned CNT_W       = ROUND_WIDTH + NODE_ADDR_WIDTH + 1;
  localparam int unsigned POP_W       = NODE_ADDR_WIDTH + 1;
  localparam int unsigned DRAIN_LIMIT = NODE_ADDR_WIDTH + DRAIN_OFFSET;
  localparam int unsigned DRN_W       = $clog2(DRAIN_LIMIT + 1);

  iconn_state_e                        state_q;
  logic                                busy_q;
  logic                                done_q;
  logic                                err_q;
  logic [ROUND_WIDTH-1:0]              round_idx_q;
  logic [ROUND_WIDTH-1:0]              round_num_q;
  logic [CNT_W-1:0]                    tx_cnt_q;
  logic [CNT_W-1:0]                    rx_cnt_q;
  logic [DRN_W-1:0]                    drain_cnt_q;
  logic                                rd_vld_q;
  logic [NN-1:0][NODE_ADDR_WIDTH-1:0]  ain_q;
  logic [NN-1:0][DATA_WIDTH-1:0]       din_q;
  logic [NN-1:0]                       din_valid_q;
  logic [POP_W-1:0]                    tx_pop;
  logic [POP_W-1:0]                    rx_pop;
  logic                                last_round;
  logic                                overflow;

  iconn_popcount #(.N(NN), .CW(POP_W)) u_tx_pop (
    .vec_i (src_rd_mask),
    .cnt_o (tx_pop)
  );

  iconn_popcount #(.N(NN), .CW(POP_W)) u_rx_pop (
    .vec_i (dout_valid),
    .cnt_o (rx_pop)
  );

  assign src_rd_en    = (state_q == ISSUE) && !pause;
  assign src_rd_round = round_idx_q;
  assign last_round   = (round_idx_q == round_num_q - ROUND_WIDTH'(1));
  assign overflow     = (rx_cnt_q > tx_cnt_q);

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ain       = ain_q;
  assign din       = din_q;
  assign din_valid = din_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      round_idx_q <= '0;
      round_num_q <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      drain_cnt_q <= '0;
      rd_vld_q    <= 1'b0;
      ain_q       <= '0;
      din_q       <= '0;
      din_valid_q <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= src_rd_en;

      // Source data lands one cycle after the read; register it onto the network inputs.
      if (rd_vld_q) begin
        ain_q       <= src_rd_addr;
        din_q       <= src_rd_data;
        din_valid_q <= src_rd_mask;
        tx_cnt_q    <= tx_cnt_q + CNT_W'(tx_pop);
      end else begin
        din_valid_q <= '0;
      end

      if (busy_q) begin
        rx_cnt_q <= rx_cnt_q + CNT_W'(rx_pop);
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            err_q       <= 1'b0;
            round_idx_q <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            round_num_q <= round_num;
            busy_q      <= 1'b1;
            if (round_num != '0) begin
              state_q <= ISSUE;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (overflow) begin
            err_q   <= 1'b1;
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (src_rd_en) begin
            round_idx_q <= round_idx_q + ROUND_WIDTH'(1);
            if (last_round) begin
              state_q     <= DRAIN;
              drain_cnt_q <= '0;
            end
          end
        end
        DRAIN: begin
          // rd_vld_q gates completion until the final read has been injected and counted.
          if (overflow) begin
            err_q   <= 1'b1;
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (!rd_vld_q && (rx_cnt_q == tx_cnt_q)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (drain_cnt_q == DRN_W'(DRAIN_LIMIT - 1)) begin
            err_q   <= 1'b1;
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRN_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iconn_issue.sv
// Directed bench for iconn_issue with a source-memory responder and a fixed-latency network model.
module tb_iconn_issue;

  localparam int unsigned AW  = 5;
  localparam int unsigned NN  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned RW  = 8;
  localparam int unsigned LAT = AW - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [RW-1:0]            round_num;
  logic                     pause;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic                     src_rd_en;
  logic [RW-1:0]            src_rd_round;
  logic [NN-1:0][AW-1:0]    src_rd_addr;
  logic [NN-1:0][DW-1:0]    src_rd_data;
  logic [NN-1:0]            src_rd_mask;
  logic [NN-1:0][AW-1:0]    ain;
  logic [NN-1:0][DW-1:0]    din;
  logic [NN-1:0]            din_valid;
  logic [NN-1:0]            dout_valid;

  logic [NN-1:0]            pipe [LAT];
  logic [NN-1:0]            drop_mask;
  logic [NN-1:0]            mask_tbl [4];

  int n_chk  = 0;
  int n_pass = 0;

  int            ncyc;
  int            rd_n;
  int            rd_paused;
  logic [RW-1:0] rd_log [8];
  int            done_n;
  int            done_cyc;
  int            tx_seen;
  int            rx_seen;
  logic          dv_seen;
  logic [NN-1:0] first_dv;
  int            first_dv_cyc;
  logic [DW-1:0] din7;
  logic [AW-1:0] ain7;

  iconn_issue #(
    .NODE_ADDR_WIDTH (AW),
    .DATA_WIDTH      (DW),
    .ROUND_WIDTH     (RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .round_num    (round_num),
    .pause        (pause),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .src_rd_en    (src_rd_en),
    .src_rd_round (src_rd_round),
    .src_rd_addr  (src_rd_addr),
    .src_rd_data  (src_rd_data),
    .src_rd_mask  (src_rd_mask),
    .ain          (ain),
    .din          (din),
    .din_valid    (din_valid),
    .dout_valid   (dout_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] data_of(input logic [RW-1:0] r, input int i);
    return {r, 8'hA5, 16'hBEEF, 32'(i)};
  endfunction

  // Source memory: answers one cycle after a read; mask is all-ones otherwise so stray sampling shows up.
  always @(posedge clk) begin
    if (src_rd_en) begin
      src_rd_mask <= mask_tbl[src_rd_round[1:0]];
      for (int i = 0; i < NN; i++) begin
        src_rd_addr[i] <= AW'((i + int'(src_rd_round)) % NN);
        src_rd_data[i] <= data_of(src_rd_round, i);
      end
    end else begin
      src_rd_mask <= '1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= din_valid;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign dout_valid = pipe[LAT-1] & ~drop_mask;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr();
    ncyc = 0; rd_n = 0; rd_paused = 0; done_n = 0; done_cyc = -1;
    tx_seen = 0; rx_seen = 0; dv_seen = 1'b0; first_dv = '0; first_dv_cyc = -1;
    din7 = '0; ain7 = '0;
  endtask

  task automatic step(input int k);
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      if (src_rd_en) begin
        if (rd_n < 8) rd_log[rd_n] = src_rd_round;
        rd_n++;
        if (pause) rd_paused++;
      end
      if (done) begin
        done_n++;
        done_cyc = ncyc;
      end
      if (busy) rx_seen += $countones(dout_valid);
      tx_seen += $countones(din_valid);
      if (din_valid != '0 && !dv_seen) begin
        dv_seen      = 1'b1;
        first_dv     = din_valid;
        first_dv_cyc = ncyc;
      end
      if (din_valid[7]) begin
        din7 = din[7];
        ain7 = ain[7];
      end
      @(posedge clk);
      #1;
      ncyc++;
    end
  endtask

  task automatic begin_job(input logic [RW-1:0] rn);
    clr();
    start     = 1'b1;
    round_num = rn;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (done_n == 0 && k < limit) begin
      step(1);
      k++;
    end
    if (done_n == 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
    step(2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; round_num = '0; drop_mask = '0;
    mask_tbl[0] = '1;
    mask_tbl[1] = 32'hF0F0_F0F0;
    mask_tbl[2] = 32'h8000_0001;
    mask_tbl[3] = '0;
    clr();
    @(posedge clk);
    #1;
    step(3);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_err",   64'(err), 64'd0);
    chk("rst_rd_en", 64'(src_rd_en), 64'd0);
    chk("rst_dv",    64'(din_valid), 64'd0);
    chk("rst_ain",   64'(|ain), 64'd0);
    chk("rst_din",   64'(|din), 64'd0);
    rst = 1'b0;
    step(1);

    // One round, full mask, identity addresses.
    begin_job(8'd1);
    wait_done("a", 40);
    chk("a_rd_n",     64'(rd_n), 64'd1);
    chk("a_rd_round", 64'(rd_log[0]), 64'd0);
    chk("a_dv",       64'(first_dv), 64'hFFFF_FFFF);
    chk("a_dv_cyc",   64'(first_dv_cyc), 64'd3);
    chk("a_tx",       64'(tx_seen), 64'd32);
    chk("a_rx",       64'(rx_seen), 64'd32);
    chk("a_done_cyc", 64'(done_cyc), 64'd9);
    chk("a_done_n",   64'(done_n), 64'd1);
    chk("a_err",      64'(err), 64'd0);
    chk("a_din7",     din7, data_of(8'd0, 7));
    chk("a_ain7",     64'(ain7), 64'd7);
    chk("a_busy",     64'(busy), 64'd0);

    // Three rounds with two paused cycles after the first read.
    begin_job(8'd3);
    step(1);
    pause = 1'b1;
    step(2);
    pause = 1'b0;
    wait_done("b", 40);
    chk("b_rd_n",     64'(rd_n), 64'd3);
    chk("b_rd0",      64'(rd_log[0]), 64'd0);
    chk("b_rd1",      64'(rd_log[1]), 64'd1);
    chk("b_rd2",      64'(rd_log[2]), 64'd2);
    chk("b_rd_pause", 64'(rd_paused), 64'd0);
    chk("b_tx",       64'(tx_seen), 64'd50);
    chk("b_rx",       64'(rx_seen), 64'd50);
    chk("b_done_cyc", 64'(done_cyc), 64'd13);
    chk("b_err",      64'(err), 64'd0);
    chk("b_din7",     din7, data_of(8'd1, 7));
    chk("b_ain7",     64'(ain7), 64'd8);

    // Zero-round job.
    begin_job(8'd0);
    wait_done("c", 10);
    chk("c_done_cyc", 64'(done_cyc), 64'd1);
    chk("c_done_n",   64'(done_n), 64'd1);
    chk("c_rd_n",     64'(rd_n), 64'd0);
    chk("c_err",      64'(err), 64'd0);

    // One packet lost in the network: drain timeout.
    drop_mask = 32'h0000_0008;
    begin_job(8'd1);
    wait_done("d", 40);
    chk("d_done_cyc", 64'(done_cyc), 64'd11);
    chk("d_done_n",   64'(done_n), 64'd1);
    chk("d_rx",       64'(rx_seen), 64'd31);
    chk("d_err",      64'(err), 64'd1);
    step(3);
    chk("d_err_hold", 64'(err), 64'd1);
    chk("d_idle",     64'(busy), 64'd0);
    drop_mask = '0;

    // Start pulsed during ISSUE is ignored.
    begin_job(8'd3);
    chk("e_err_clr",  64'(err), 64'd0);
    chk("e_busy",     64'(busy), 64'd1);
    step(1);
    start = 1'b1;
    round_num = 8'd5;
    step(1);
    start = 1'b0;
    wait_done("e", 40);
    chk("e_rd_n",     64'(rd_n), 64'd3);
    chk("e_rd2",      64'(rd_log[2]), 64'd2);
    chk("e_done_n",   64'(done_n), 64'd1);
    chk("e_done_cyc", 64'(done_cyc), 64'd11);
    chk("e_err",      64'(err), 64'd0);

    // Reset mid-DRAIN, then start on the first cycle after release.
    begin_job(8'd1);
    step(2);
    rst = 1'b1;
    step(2);
    chk("f_busy",     64'(busy), 64'd0);
    chk("f_done",     64'(done), 64'd0);
    chk("f_err",      64'(err), 64'd0);
    chk("f_rd_en",    64'(src_rd_en), 64'd0);
    chk("f_dv",       64'(din_valid), 64'd0);
    chk("f_ain",      64'(|ain), 64'd0);
    chk("f_din",      64'(|din), 64'd0);
    chk("f_no_done",  64'(done_n), 64'd0);
    rst = 1'b0;
    begin_job(8'd1);
    chk("f_accept",   64'(busy), 64'd1);
    wait_done("f", 40);
    chk("f_done_cyc", 64'(done_cyc), 64'd9);
    chk("f_tx",       64'(tx_seen), 64'd32);
    chk("f_rx",       64'(rx_seen), 64'd32);
    chk("f_err2",     64'(err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
